instr_pipe: RTL and testbench
=============================

INSTR_PIPE -- requirements
Module: instr_pipe

Interface
REQ-001 SHALL have port: clk  input  1  sole clock, all state on rising edge.
REQ-002 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have port: stall  input  1  freeze request from hazard logic.
REQ-004 SHALL have port: pc_next  input  32  next-PC from branch/jump logic.
REQ-005 SHALL have port: instr_f  input  32  instruction memory data for PC.
REQ-006 SHALL have port: regwrite_d  input  1  decoded register-write flag of InstrD.
REQ-007 SHALL have port: PC  output  32  fetch-stage program counter.
REQ-008 SHALL have ports: InstrD, InstrE, InstrM, InstrW  output  32 each  per-stage instruction.
REQ-009 SHALL have ports: PCD, PCE, PCM, PCW  output  32 each  per-stage PC.
REQ-010 SHALL have ports: regWriteE, regWriteM, regWriteW  output  1 each  per-stage write flag.
REQ-011 SHALL have ports: validD, validE, validM, validW  output  1 each  stage holds real instruction.

Function
REQ-012 SHALL register all outputs; no combinational path from any input to any output.
REQ-013 stall=0: PC<=pc_next; D<=(instr_f, PC, valid 1); E<=D plus regwrite_d; M<=E; W<=M, each edge.
REQ-014 stall=1: PC and all D-stage registers SHALL hold value.
REQ-015 stall=1: E stage SHALL load bubble -- InstrE=0, PCE=0, regWriteE=0, validE=0.
REQ-016 stall=1: M<=E and W<=M SHALL still advance (older instructions drain).
REQ-017 Bubble SHALL propagate E->M->W unchanged, regWrite 0 and valid 0 in every stage.
REQ-018 regWriteE SHALL load regwrite_d AND validD; invalid D never produces a write.
REQ-019 Consecutive stall cycles SHALL hold PC/D indefinitely, inserting one bubble per cycle.
REQ-020 Stall deasserted SHALL resume next edge with held D instruction entering E exactly once.
REQ-021 PC SHALL be plain 32-bit register, no alignment check, wraps 0xFFFF_FFFC -> pc_next as given.

Reset
REQ-022 reset=1 at edge SHALL override stall and all other inputs.
REQ-023 Reset values: PC=32'h0000_3000; all Instr*, PC[DEMW]=0; all regWrite*, valid*=0.
REQ-024 Reset mid-operation SHALL discard every in-flight instruction; first post-reset edge with reset=0 loads D from PC 0x3000.

Configuration
REQ-025 Macro PERF_CNT_EN defined: SHALL add outputs cyc_cnt, stall_cnt, retire_cnt (output, 32 each).
REQ-026 With PERF_CNT_EN: cyc_cnt +1 per non-reset edge; stall_cnt +1 per edge with stall=1; retire_cnt +1 per edge validW=1; all reset to 0, wrap 0xFFFF_FFFF->0.
REQ-027 Without PERF_CNT_EN: counter ports and logic SHALL be absent; all other behaviour identical.

Verification
REQ-028 Reset then 4 edges, stall=0, pc_next=PC+4, instr_f=0x2408_0001 -> PCW=0x3000, validW=1, PC=0x3010.
REQ-029 Load in E (0x8C08_0000, regWriteE=1), stall=1 one cycle -> InstrD/PCD held, next InstrE=0, regWriteE=0, load advances to M.
REQ-030 stall=1 for 3 cycles -> 3 consecutive bubbles at W (validW=0 x3), PC unchanged, held D enters E once on release.
REQ-031 reset asserted with stall=1 and full pipe -> next edge all valid*=0, PC=0x3000; stall ignored.
REQ-032 regwrite_d=1 while validD=0 (first cycle after reset) -> regWriteE=0.
REQ-033 PERF_CNT_EN: 10 cycles, 2 stalled, pipe full -> cyc_cnt=10, stall_cnt=2, retire_cnt=number of validW edges; preload stall_cnt=0xFFFF_FFFF, stall -> 0.

Source files
------------

// File: rtl/instr_pipe.sv
// instr_pipe: fetch PC plus D/E/M/W instruction pipeline registers with stall-bubble insertion; optional perf counters under PERF_CNT_EN
module instr_pipe (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic [31:0] pc_next,
   input  logic [31:0] instr_f,
   input  logic        regwrite_d,
   output logic [31:0] PC,
   output logic [31:0] InstrD,
   output logic [31:0] InstrE,
   output logic [31:0] InstrM,
   output logic [31:0] InstrW,
   output logic [31:0] PCD,
   output logic [31:0] PCE,
   output logic [31:0] PCM,
   output logic [31:0] PCW,
   output logic        regWriteE,
   output logic        regWriteM,
   output logic        regWriteW,
   output logic        validD,
   output logic        validE,
   output logic        validM,
   output logic        validW
`ifdef PERF_CNT_EN
  ,output logic [31:0] cyc_cnt,
   output logic [31:0] stall_cnt,
   output logic [31:0] retire_cnt
`endif
);
   localparam logic [31:0] PC_RESET = 32'h0000_3000;

   logic [31:0] pc_q, pc_d;
   logic [31:0] d_instr_q, d_instr_d, d_pc_q, d_pc_d;
   logic        d_valid_q, d_valid_d;
   logic [31:0] e_instr_q, e_instr_d, e_pc_q, e_pc_d;
   logic        e_rw_q, e_rw_d, e_valid_q, e_valid_d;
   logic [31:0] m_instr_q, m_instr_d, m_pc_q, m_pc_d;
   logic        m_rw_q, m_rw_d, m_valid_q, m_valid_d;
   logic [31:0] w_instr_q, w_instr_d, w_pc_q, w_pc_d;
   logic        w_rw_q, w_rw_d, w_valid_q, w_valid_d;

   // Fetch and decode hold on stall; otherwise fetch follows pc_next and D captures the fetched word
   always_comb begin
      pc_d      = stall ? pc_q      : pc_next;
      d_instr_d = stall ? d_instr_q : instr_f;
      d_pc_d    = stall ? d_pc_q    : pc_q;
      d_valid_d = stall ? d_valid_q : 1'b1;
   end

   // Execute takes the decoded instruction, or a bubble while decode is frozen; writes need a real D
   always_comb begin
      e_instr_d = stall ? 32'h0 : d_instr_q;
      e_pc_d    = stall ? 32'h0 : d_pc_q;
      e_rw_d    = ~stall & regwrite_d & d_valid_q;
      e_valid_d = ~stall & d_valid_q;
   end

   // Memory and writeback always advance so older instructions drain during a stall
   always_comb begin
      m_instr_d = e_instr_q;
      m_pc_d    = e_pc_q;
      m_rw_d    = e_rw_q;
      m_valid_d = e_valid_q;
      w_instr_d = m_instr_q;
      w_pc_d    = m_pc_q;
      w_rw_d    = m_rw_q;
      w_valid_d = m_valid_q;
   end

   // Pipeline state; reset discards every in-flight instruction and restarts fetch at the boot vector
   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q      <= PC_RESET;
         d_instr_q <= 32'h0;
         d_pc_q    <= 32'h0;
         d_valid_q <= 1'b0;
         e_instr_q <= 32'h0;
         e_pc_q    <= 32'h0;
         e_rw_q    <= 1'b0;
         e_valid_q <= 1'b0;
         m_instr_q <= 32'h0;
         m_pc_q    <= 32'h0;
         m_rw_q    <= 1'b0;
         m_valid_q <= 1'b0;
         w_instr_q <= 32'h0;
         w_pc_q    <= 32'h0;
         w_rw_q    <= 1'b0;
         w_valid_q <= 1'b0;
      end else begin
         pc_q      <= pc_d;
         d_instr_q <= d_instr_d;
         d_pc_q    <= d_pc_d;
         d_valid_q <= d_valid_d;
         e_instr_q <= e_instr_d;
         e_pc_q    <= e_pc_d;
         e_rw_q    <= e_rw_d;
         e_valid_q <= e_valid_d;
         m_instr_q <= m_instr_d;
         m_pc_q    <= m_pc_d;
         m_rw_q    <= m_rw_d;
         m_valid_q <= m_valid_d;
         w_instr_q <= w_instr_d;
         w_pc_q    <= w_pc_d;
         w_rw_q    <= w_rw_d;
         w_valid_q <= w_valid_d;
      end
   end

   assign PC        = pc_q;
   assign InstrD    = d_instr_q;
   assign InstrE    = e_instr_q;
   assign InstrM    = m_instr_q;
   assign InstrW    = w_instr_q;
   assign PCD       = d_pc_q;
   assign PCE       = e_pc_q;
   assign PCM       = m_pc_q;
   assign PCW       = w_pc_q;
   assign regWriteE = e_rw_q;
   assign regWriteM = m_rw_q;
   assign regWriteW = w_rw_q;
   assign validD    = d_valid_q;
   assign validE    = e_valid_q;
   assign validM    = m_valid_q;
   assign validW    = w_valid_q;

`ifdef PERF_CNT_EN
   logic [31:0] cyc_q, cyc_d, stall_q, stall_d, retire_q, retire_d;

   // Free-running event counters; 32-bit adds wrap naturally
   always_comb begin
      cyc_d    = cyc_q + 32'd1;
      stall_d  = stall_q + {31'b0, stall};
      retire_d = retire_q + {31'b0, w_valid_q};
   end

   // Counter state, cleared by reset
   always_ff @(posedge clk) begin
      if (reset) begin
         cyc_q    <= 32'h0;
         stall_q  <= 32'h0;
         retire_q <= 32'h0;
      end else begin
         cyc_q    <= cyc_d;
         stall_q  <= stall_d;
         retire_q <= retire_d;
      end
   end

   assign cyc_cnt    = cyc_q;
   assign stall_cnt  = stall_q;
   assign retire_cnt = retire_q;
`endif
endmodule

// File: tb/tb_instr_pipe.sv
// tb_instr_pipe: randomized scoreboard bench for instr_pipe
module tb_instr_pipe;
   logic        clk = 1'b0;
   logic        reset, stall, regwrite_d;
   logic [31:0] pc_next, instr_f;
   logic [31:0] PC, InstrD, InstrE, InstrM, InstrW, PCD, PCE, PCM, PCW;
   logic        regWriteE, regWriteM, regWriteW, validD, validE, validM, validW;
`ifdef PERF_CNT_EN
   logic [31:0] cyc_cnt, stall_cnt, retire_cnt;
   logic [31:0] m_cyc = 0, m_stl = 0, m_ret = 0;
`endif

   instr_pipe dut (
      .clk(clk), .reset(reset), .stall(stall), .pc_next(pc_next), .instr_f(instr_f),
      .regwrite_d(regwrite_d), .PC(PC),
      .InstrD(InstrD), .InstrE(InstrE), .InstrM(InstrM), .InstrW(InstrW),
      .PCD(PCD), .PCE(PCE), .PCM(PCM), .PCW(PCW),
      .regWriteE(regWriteE), .regWriteM(regWriteM), .regWriteW(regWriteW),
      .validD(validD), .validE(validE), .validM(validM), .validW(validW)
`ifdef PERF_CNT_EN
     ,.cyc_cnt(cyc_cnt), .stall_cnt(stall_cnt), .retire_cnt(retire_cnt)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc;
      logic        rw;
      int          due;
   } ent_t;

   ent_t        q[$];
   ent_t        x;
   int          tests = 0, fails = 0, edge_n = 0;
   logic [31:0] m_pc = 32'h3000, m_di = 0, m_dp = 0;
   logic        m_dv = 1'b0, exp_vw = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, edge_n);
      end
   endtask

   // One clock: drive inputs, let the edge happen, update the reference model
   task automatic step(input logic r, input logic s, input logic [31:0] pn, input logic [31:0] ins, input logic rw);
      reset = r; stall = s; pc_next = pn; instr_f = ins; regwrite_d = rw;
      @(posedge clk);
      edge_n++;
`ifdef PERF_CNT_EN
      if (r) begin m_cyc = 0; m_stl = 0; m_ret = 0; end
      else begin m_cyc++; m_stl += {31'b0, s}; m_ret += {31'b0, exp_vw}; end
`endif
      if (r) begin
         q.delete();
         m_pc = 32'h3000; m_di = 0; m_dp = 0; m_dv = 0;
      end else if (!s) begin
         if (m_dv) q.push_back('{instr: m_di, pc: m_dp, rw: rw, due: edge_n + 2});
         m_di = ins; m_dp = m_pc; m_dv = 1; m_pc = pn;
      end
      #2;
   endtask

   // Monitor: retirements at W must match the scoreboard in order and timing; idle W must be a clean bubble
   initial forever begin
      @(posedge clk);
      #1;
      if (edge_n > 0) begin
         if (q.size() > 0 && q[0].due <= edge_n) begin
            x = q.pop_front();
            chk("retire_edge", edge_n, x.due);
            chk("validW", validW, 1);
            chk("InstrW", InstrW, x.instr);
            chk("PCW", PCW, x.pc);
            chk("regWriteW", regWriteW, x.rw);
            exp_vw = 1'b1;
         end else begin
            chk("bubbleW", {validW, regWriteW, InstrW, PCW}, 0);
            exp_vw = 1'b0;
         end
         chk("PC", PC, m_pc);
         chk("PCD", PCD, m_dp);
         chk("InstrD", InstrD, m_di);
         chk("validD", validD, m_dv);
`ifdef PERF_CNT_EN
         chk("cyc_cnt", cyc_cnt, m_cyc);
         chk("stall_cnt", stall_cnt, m_stl);
         chk("retire_cnt", retire_cnt, m_ret);
`endif
      end
   end

   initial begin
      logic [31:0] held_pc;
      int          sel;
      step(1, 0, 0, 0, 0);
      step(1, 1, 32'h1234, 32'hFFFF_FFFF, 1);
      chk("reset_PC", PC, 32'h3000);
      chk("reset_valid", {validD, validE, validM, validW, regWriteE, regWriteM, regWriteW}, 0);
      // first edge after reset: D was invalid, so no write may reach E
      step(0, 0, m_pc + 4, 32'h2408_0001, 1);
      chk("rwE_invalidD", {regWriteE, validE}, 0);
      for (int i = 0; i < 3; i++) step(0, 0, m_pc + 4, 32'h2408_0001, 0);
      chk("fill_PCW", PCW, 32'h3000);
      chk("fill_validW", validW, 1);
      chk("fill_PC", PC, 32'h3010);
      // load reaches E, then a one-cycle stall
      step(0, 0, m_pc + 4, 32'h8C08_0000, 1);
      step(0, 0, m_pc + 4, 32'h2409_0002, 1);
      chk("load_InstrE", InstrE, 32'h8C08_0000);
      chk("load_rwE", regWriteE, 1);
      held_pc = PCD;
      step(0, 1, 32'hDEAD_0000, 32'hBAD0_BAD0, 1);
      chk("stall_InstrD", InstrD, 32'h2409_0002);
      chk("stall_PCD", PCD, held_pc);
      chk("stall_bubbleE", {InstrE, PCE, regWriteE, validE}, 0);
      chk("stall_InstrM", InstrM, 32'h8C08_0000);
      chk("stall_rwM", regWriteM, 1);
      // three consecutive stalls, then release
      held_pc = PC;
      for (int i = 0; i < 3; i++) begin
         step(0, 1, $urandom, $urandom, 1);
         chk("multi_stall_PC", PC, held_pc);
      end
      step(0, 0, m_pc + 4, 32'h1111_1111, 0);
      chk("release_InstrE", InstrE, 32'h2409_0002);
      // reset with stall on a full pipe
      for (int i = 0; i < 4; i++) step(0, 0, m_pc + 4, $urandom, 1);
      step(1, 1, 32'h5555_5550, $urandom, 1);
      chk("rst_stall_valid", {validD, validE, validM, validW}, 0);
      chk("rst_stall_PC", PC, 32'h3000);
      step(0, 0, m_pc + 4, 32'h2408_0001, 0);
      chk("post_rst_PCD", PCD, 32'h3000);
      // randomized traffic including wrap-around fetch addresses and occasional resets
      for (int i = 0; i < 1500; i++) begin
         sel = $urandom_range(99);
         step($urandom_range(99) < 3, $urandom_range(99) < 30,
              sel < 80 ? m_pc + 4 : (sel < 90 ? 32'hFFFF_FFFC : $urandom),
              $urandom, 1'($urandom_range(1)));
      end
      for (int i = 0; i < 4; i++) step(0, 0, m_pc + 4, $urandom, 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
